// File: rtl/tdm_demux16.sv
// Receive-side 1:16 TDM demultiplexer: steers framed serial slots into shadow registers
// and publishes whole frames on q. Optional even-parity beat enabled by TDM_DEMUX_PARITY_EN.
module tdm_demux16 #(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  sync,
  input  logic [WIDTH-1:0]      din,
  output logic [16*WIDTH-1:0]   q,
  output logic                  frame_valid,
  output logic [3:0]            slot,
  output logic                  locked,
  output logic                  sync_err,
  output logic                  par_err
);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

`ifdef TDM_DEMUX_PARITY_EN
  // Slot 15 must be held until the parity beat has been checked.
  localparam int NSHADOW = 16;
`else
  // Slot 15 goes straight from din into q, so it needs no shadow entry.
  localparam int NSHADOW = 15;
`endif

  state_t                    state_q, state_d;
  logic [3:0]                slot_q, slot_d;
  logic [WIDTH-1:0]          shadow [NSHADOW];
  logic [NSHADOW*WIDTH-1:0]  shadow_flat;
  logic [16*WIDTH-1:0]       frame_word;
  logic [16*WIDTH-1:0]       q_q;
  logic                      frame_valid_q, sync_err_q;
  logic                      shadow_we;
  logic [3:0]                shadow_idx;
  logic                      publish, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic                      par_phase_q, par_phase_d;
  logic                      par_err_q, par_err_d;
`endif

  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < NSHADOW; k++) begin
      shadow_flat[k*WIDTH +: WIDTH] = shadow[k];
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  assign frame_word = shadow_flat;
`else
  assign frame_word = {din, shadow_flat};
`endif

  // Next-state and per-beat decisions.
  // NOTE: every variable gets a default at the top so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    shadow_we  = 1'b0;
    shadow_idx = slot_q;
    publish    = 1'b0;
    sync_err_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    par_phase_d = par_phase_q;
    par_err_d   = 1'b0;
`endif

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            shadow_we  = 1'b1;
            shadow_idx = 4'd0;
            slot_d     = 4'd1;
            state_d    = RECV;
          end
        end

        RECV: begin
`ifdef TDM_DEMUX_PARITY_EN
          if (par_phase_q) begin
            par_phase_d = 1'b0;
            if (sync) begin
              // Sync on the parity beat restarts the frame from this beat.
              sync_err_d = 1'b1;
              shadow_we  = 1'b1;
              shadow_idx = 4'd0;
              slot_d     = 4'd1;
            end else begin
              slot_d = 4'd0;
              if (din[0] == ^shadow_flat) publish   = 1'b1;
              else                        par_err_d = 1'b1;
            end
          end else
`endif
          if (sync) begin
            // Mid-frame sync discards the partial frame and starts over here.
            sync_err_d = (slot_q != 4'd0);
            shadow_we  = 1'b1;
            shadow_idx = 4'd0;
            slot_d     = 4'd1;
          end else if (slot_q == 4'd0) begin
            sync_err_d = 1'b1;
            slot_d     = 4'd0;
            state_d    = HUNT;
          end else if (slot_q == 4'd15) begin
`ifdef TDM_DEMUX_PARITY_EN
            shadow_we   = 1'b1;
            par_phase_d = 1'b1;
`else
            publish = 1'b1;
            slot_d  = 4'd0;
`endif
          end else begin
            shadow_we = 1'b1;
            slot_d    = slot_q + 4'd1;
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= 4'd0;
      q_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_phase_q   <= 1'b0;
      par_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      frame_valid_q <= publish;
      sync_err_q    <= sync_err_d;
      if (publish) q_q <= frame_word;
`ifdef TDM_DEMUX_PARITY_EN
      par_phase_q   <= par_phase_d;
      par_err_q     <= par_err_d;
`endif
    end
  end

  // NOTE: the shadow bank is reset explicitly so a half-received frame never
  // survives reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSHADOW; k++) shadow[k] <= '0;
    end else if (shadow_we) begin
      shadow[shadow_idx] <= din;
    end
  end

  assign q           = q_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign locked      = (state_q == RECV);
  assign sync_err    = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err     = par_err_q;
`else
  assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed self-checking bench for tdm_demux16 (WIDTH=1); the parity scenario is
// compiled in only when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux16;
  localparam int WIDTH = 1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en, sync;
  logic [WIDTH-1:0]    din;
  logic [16*WIDTH-1:0] q;
  logic                frame_valid, locked, sync_err, par_err;
  logic [3:0]          slot;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tdm_demux16 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .din(din),
    .q(q), .frame_valid(frame_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err), .par_err(par_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic beat(input logic e, input logic s, input logic [WIDTH-1:0] d);
    en = e; sync = s; din = d;
    @(posedge clk); #1;
  endtask

  // Slots first..last (<=14) of word; sync on slot 0. Optional en=0 gap after each
  // beat carries sync=1 and inverted data, which must be ignored.
  task automatic send_slots(input logic [15:0] word, input int first, input int last,
                            input bit gap, input logic [15:0] q_hold, input string tag);
    for (int k = first; k <= last; k++) begin
      beat(1'b1, k == 0, word[k]);
      check({tag, "_fv"},   frame_valid, 32'd0);
      check({tag, "_serr"}, sync_err,    32'd0);
      check({tag, "_perr"}, par_err,     32'd0);
      check({tag, "_slot"}, slot,        32'(k + 1));
      check({tag, "_lock"}, locked,      32'd1);
      check({tag, "_q"},    q,           32'(q_hold));
      if (gap) begin
        beat(1'b0, 1'b1, ~word[k]);
        check({tag, "_gap_slot"}, slot,        32'(k + 1));
        check({tag, "_gap_fv"},   frame_valid, 32'd0);
      end
    end
  endtask

  // Slot 15 (plus parity beat when enabled) and the publish checks.
  task automatic finish_frame(input logic [15:0] word, input string tag);
    beat(1'b1, 1'b0, word[15]);
`ifdef TDM_DEMUX_PARITY_EN
    check({tag, "_pre_fv"},   frame_valid, 32'd0);
    check({tag, "_pre_slot"}, slot,        32'd15);
    beat(1'b1, 1'b0, ^word);
`endif
    check({tag, "_end_fv"},   frame_valid, 32'd1);
    check({tag, "_end_q"},    q,           32'(word));
    check({tag, "_end_slot"}, slot,        32'd0);
    check({tag, "_end_lock"}, locked,      32'd1);
    check({tag, "_end_serr"}, sync_err,    32'd0);
    check({tag, "_end_perr"}, par_err,     32'd0);
  endtask

  task automatic do_reset();
    en = 1'b0; sync = 1'b0; din = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    do_reset();
    check("rst_q", q, 32'd0);
    check("rst_fv", frame_valid, 32'd0);
    check("rst_slot", slot, 32'd0);
    check("rst_lock", locked, 32'd0);
    check("rst_serr", sync_err, 32'd0);
    check("rst_perr", par_err, 32'd0);

    // Slot k carries k[0]: 0xAAAA, en every cycle; pulse drops on idle cycle.
    send_slots(16'hAAAA, 0, 14, 1'b0, 16'h0000, "alt");
    finish_frame(16'hAAAA, "alt");
    beat(1'b0, 1'b0, 1'b0);
    check("alt_idle_fv", frame_valid, 32'd0);
    check("alt_idle_q", q, 32'hAAAA);

    // Same frame with en=0 on alternate cycles, from a clean reset.
    do_reset();
    send_slots(16'hAAAA, 0, 14, 1'b1, 16'h0000, "gated");
    finish_frame(16'hAAAA, "gated");

    // HUNT ignores unsynced beats without error.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b0, 1'b1);
      check("hunt_serr", sync_err, 32'd0);
      check("hunt_lock", locked, 32'd0);
      check("hunt_slot", slot, 32'd0);
    end
    send_slots(16'hFFFF, 0, 14, 1'b0, 16'h0000, "ones");
    finish_frame(16'hFFFF, "ones");

    // Back-to-back frames; pulses come one frame length apart.
    send_slots(16'h1234, 0, 14, 1'b0, 16'hFFFF, "b2b1");
    finish_frame(16'h1234, "b2b1");
    send_slots(16'h5678, 0, 14, 1'b0, 16'h1234, "b2b2");
    finish_frame(16'h5678, "b2b2");

    // Sync at slot 7 aborts frame; that beat starts a new frame 0x0F0F.
    send_slots(16'h9ABC, 0, 6, 1'b0, 16'h5678, "abort");
    beat(1'b1, 1'b1, 1'b1);
    check("abort_serr", sync_err, 32'd1);
    check("abort_fv", frame_valid, 32'd0);
    check("abort_q", q, 32'h5678);
    check("abort_slot", slot, 32'd1);
    check("abort_lock", locked, 32'd1);
    send_slots(16'h0F0F, 1, 14, 1'b0, 16'h5678, "resync");
    finish_frame(16'h0F0F, "resync");

    // Missing sync at slot 0 loses lock.
    beat(1'b1, 1'b0, 1'b1);
    check("nosync_serr", sync_err, 32'd1);
    check("nosync_lock", locked, 32'd0);
    check("nosync_slot", slot, 32'd0);
    check("nosync_fv", frame_valid, 32'd0);
    check("nosync_q", q, 32'h0F0F);
    beat(1'b0, 1'b0, 1'b0);
    check("nosync_drop", sync_err, 32'd0);

    // Asynchronous reset in the middle of a frame.
    send_slots(16'h5A5A, 0, 8, 1'b0, 16'h0F0F, "mid");
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q, 32'd0);
    check("arst_lock", locked, 32'd0);
    check("arst_slot", slot, 32'd0);
    check("arst_fv", frame_valid, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_slots(16'h00C3, 0, 14, 1'b0, 16'h0000, "clean");
    finish_frame(16'h00C3, "clean");

`ifdef TDM_DEMUX_PARITY_EN
    // Bad parity: error pulse, q keeps previous frame.
    send_slots(16'h0003, 0, 14, 1'b0, 16'h00C3, "pbad");
    beat(1'b1, 1'b0, 1'b0);
    check("pbad_pre_slot", slot, 32'd15);
    beat(1'b1, 1'b0, 1'b1);
    check("pbad_perr", par_err, 32'd1);
    check("pbad_fv", frame_valid, 32'd0);
    check("pbad_q", q, 32'h00C3);
    check("pbad_slot", slot, 32'd0);
    check("pbad_lock", locked, 32'd1);
    // Good parity (XOR of 0x0003 is 0) publishes.
    send_slots(16'h0003, 0, 14, 1'b0, 16'h00C3, "pgood");
    finish_frame(16'h0003, "pgood");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
